// File: rtl/regfile_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through the register file's combinational
// read port and streams each {index, value} pair out over a valid/ready port.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low,
  // out_data/out_addr hold. out_ready is ignored when out_valid is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(LAST_REG);

  state_t state;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ra        <= FIRST;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            ra    <= FIRST;
            busy  <= 1'b1;
          end
        end
        READ: begin
          // Snapshot taken here; later writes to this register do not leak into the beat.
          out_data  <= rd;
          out_addr  <= ra;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before increment so LAST_REG at the top of the range never wraps.
            if (ra == LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              ra    <= ra + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: expected beats go into a queue when a
// dump is started; a negedge monitor pops and compares on every handshake.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ra;
  logic [15:0] rd;
  logic [15:0] out_data;
  logic [3:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic        start2;
  logic [3:0]  ra2;
  logic [15:0] rd2;
  logic [15:0] out_data2;
  logic [3:0]  out_addr2;
  logic        out_valid2;
  logic        out_ready2;
  logic        busy2;
  logic        done2;
  logic [1:0]  dbg_state2;

  logic [15:0] regs [16];

  logic [19:0] exp_q[$];
  logic [19:0] exp_q2[$];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_cnt2 = 0;
  int beat_cnt = 0;
  int stall_left = 0;
  logic [3:0] stall_addr = 4'd0;

  assign rd  = (ra  == 4'd0) ? 16'h0000 : regs[ra];
  assign rd2 = (ra2 == 4'd0) ? 16'h0000 : regs[ra2];

  regfile_dump_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FIRST_REG(0), .LAST_REG(15)) dut (
    .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  regfile_dump_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FIRST_REG(3), .LAST_REG(3)) dut_one (
    .clk(clk), .reset(reset), .start(start2), .ra(ra2), .rd(rd2),
    .out_data(out_data2), .out_addr(out_addr2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready generator: stall a chosen beat for stall_left cycles
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && out_addr == stall_addr && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // scoreboard monitor
  logic        held_v = 1'b0;
  logic [19:0] held_val;
  logic        prev_hs = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_hs2 = 1'b0;

  always @(negedge clk) begin
    if (prev_done) begin
      check("busy_after_done", {31'd0, busy}, 32'd0);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
    prev_done = done;
    if (done) begin
      done_cnt++;
      check("done_after_last_beat", {31'd0, prev_hs}, 32'd1);
      check("queue_empty_at_done", exp_q.size(), 32'd0);
      check("busy_in_done", {31'd0, busy}, 32'd1);
    end
    if (out_valid) begin
      if (held_v) check("hold_stable", {12'd0, out_addr, out_data}, {12'd0, held_val});
      held_v   = !out_ready;
      held_val = {out_addr, out_data};
    end else begin
      held_v = 1'b0;
    end
    prev_hs = out_valid && out_ready;
    if (out_valid && out_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) check("unexpected_beat", {12'd0, out_addr, out_data}, 32'hFFFFFFFF);
      else check("beat", {12'd0, out_addr, out_data}, {12'd0, exp_q.pop_front()});
    end

    if (done2) begin
      done_cnt2++;
      check("one_done_after_beat", {31'd0, prev_hs2}, 32'd1);
    end
    prev_hs2 = out_valid2 && out_ready2;
    if (out_valid2 && out_ready2) begin
      if (exp_q2.size() == 0) check("one_unexpected_beat", {12'd0, out_addr2, out_data2}, 32'hFFFFFFFF);
      else check("one_beat", {12'd0, out_addr2, out_data2}, {12'd0, exp_q2.pop_front()});
    end
  end

  // driver tasks
  task automatic push_dump();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      exp_q.push_back({a, (i == 0) ? 16'h0000 : regs[i]});
    end
  endtask

  task automatic start_dump();
    push_dump();
    beat_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("latency_edge1_valid", {31'd0, out_valid}, 32'd0);
    check("latency_edge1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("latency_edge2_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt, target);
    repeat (3) @(negedge clk);
    check("single_done", done_cnt, target);
    check("idle_after_dump", {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic wait_beat(input logic [3:0] a, input logic need_stall);
    int t;
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_addr == a && (!need_stall || !out_ready)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("wait_beat_timeout", {31'd0, (t < 300)}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    regs[1] = 16'h0002;
    regs[2] = 16'h0004;
    regs[3] = 16'h0003;
    start = 1'b0;
    start2 = 1'b0;
    out_ready2 = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ra", {28'd0, ra}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_addr", {28'd0, out_addr}, 32'd0);
    check("rst_ra_one", {28'd0, ra2}, 32'd3);
    reset = 1'b0;

    // single-register configuration
    exp_q2.push_back({4'd3, 16'h0003});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("one_done_count", done_cnt2, 32'd1);
    check("one_queue_empty", exp_q2.size(), 32'd0);
    check("one_ra_stays", {28'd0, ra2}, 32'd3);
    check("one_busy_idle", {31'd0, busy2}, 32'd0);

    // plain full dump
    start_dump();
    wait_done(1);
    check("dump1_beats", beat_cnt, 32'd16);

    // backpressure on addr 2, spurious start at beat 4
    stall_addr = 4'd2;
    stall_left = 5;
    start_dump();
    wait_beat(4'd4, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    check("dump2_beats", beat_cnt, 32'd16);

    // async reset in the middle of beat 7
    start_dump();
    wait_beat(4'd7, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    check("midrst_ra", {28'd0, ra}, 32'd0);
    start_dump();
    wait_done(3);
    check("dump3_beats", beat_cnt, 32'd16);

    // write during SEND of addr 5 keeps the captured snapshot
    stall_addr = 4'd5;
    stall_left = 5;
    start_dump();
    wait_beat(4'd5, 1'b1);
    regs[5] = 16'hBEEF;
    @(negedge clk);
    check("snapshot_held", {16'd0, out_data}, 32'h0000);
    wait_done(4);
    start_dump();
    wait_done(5);
    check("dump5_beats", beat_cnt, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
